lut_phase_gen: RTL and testbench

LUT_PHASE_GEN -- requirements
Module: lut_phase_gen

---
 rtl/lut_phase_gen.sv | 160 ++++++++++++++++
 tb/tb_lut_phase_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_phase_gen.sv
// ---------------------------------------------------------------------------
// lut_phase_gen
//
// Phase-accumulator front end for a table-lookup waveform generator. A
// PHASE_W-bit accumulator advances by a programmable tuning word. The top
// ADDRW bits of the accumulator address an external, combinational LUT.
// The returned LUT data is captured into a registered sample. The sample is
// handed to the consumer through a valid/ready handshake.
//
// Parameters
//   PHASE_W : accumulator and tuning word width
//   ADDRW   : LUT address width (must be <= PHASE_W)
//   WIDTH   : LUT data / sample width
//
// Ports
//   clk_in           : clock, all state changes on its rising edge
//   rst_in_n         : asynchronous active-low reset
//   en_in            : run enable for phase advance
//   tune_word_in     : new phase increment
//   tune_load_in     : load strobe for tune_word_in
//   phase_clr_in     : synchronous accumulator clear
//   rom_addr_out     : LUT address, taken straight from the accumulator
//   rom_data_in      : LUT data for rom_addr_out (combinational)
//   sample_out       : registered sample
//   sample_valid_out : sample_out holds an unconsumed sample
//   sample_ready_in  : consumer accepts sample_out
//   wrap_out         : one-cycle pulse when the accumulator overflows
// ---------------------------------------------------------------------------
module lut_phase_gen #(
    parameter int PHASE_W = 24,
    parameter int ADDRW   = 8,
    parameter int WIDTH   = 8
) (
    input  logic               clk_in,
    input  logic               rst_in_n,
    input  logic               en_in,
    input  logic [PHASE_W-1:0] tune_word_in,
    input  logic               tune_load_in,
    input  logic               phase_clr_in,
    output logic [ADDRW-1:0]   rom_addr_out,
    input  logic [WIDTH-1:0]   rom_data_in,
    output logic [WIDTH-1:0]   sample_out,
    output logic               sample_valid_out,
    input  logic               sample_ready_in,
    output logic               wrap_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [PHASE_W-1:0] acc_reg, acc_next;
    logic [PHASE_W-1:0] tune_reg, tune_next;
    logic [WIDTH-1:0]   sample_next;
    logic               valid_next;
    logic               wrap_next;

    logic               advance;
    logic [PHASE_W:0]   sum_full;   // extra MSB is the overflow carry

    // The LUT is asynchronous: its address comes from the accumulator
    // directly. The data it returns this cycle is what an advance captures.
    assign rom_addr_out = acc_reg[PHASE_W-1 -: ADDRW];

    assign sum_full = {1'b0, acc_reg} + {1'b0, tune_reg};

    // A new sample may be produced only when the output slot is empty or is
    // being emptied this cycle. This is what keeps a stalled sample from
    // being overwritten. It also keeps the phase from skipping.
    assign advance = en_in && !phase_clr_in &&
                     (!sample_valid_out || sample_ready_in);

    // -----------------------------------------------------------------------
    // Next-state / datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        acc_next    = acc_reg;
        tune_next   = tune_reg;
        sample_next = sample_out;
        valid_next  = sample_valid_out;
        wrap_next   = 1'b0;

        if (phase_clr_in) begin
            acc_next = '0;
        end else if (advance) begin
            acc_next = sum_full[PHASE_W-1:0];
            wrap_next = sum_full[PHASE_W];
        end

        if (advance) begin
            sample_next = rom_data_in;
            valid_next  = 1'b1;
        end else if (sample_valid_out && sample_ready_in) begin
            // The consumer took the sample and nothing replaces it. This
            // also applies during a clear. The clear itself never touches
            // the output slot, but a completed handshake still retires
            // the sample, so it cannot be seen twice.
            valid_next = 1'b0;
        end

        // The load lands at the end of the cycle. An advance in the same
        // cycle has already used the previous increment.
        if (tune_load_in) begin
            tune_next = tune_word_in;
        end
    end

    // -----------------------------------------------------------------------
    // Control state: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (en_in) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!en_in) begin
                    state_next = IDLE;
                end else if (sample_valid_out && !sample_ready_in) begin
                    state_next = STALL;
                end
            end
            STALL: begin
                // A held sample pins the state here, even if en_in drops.
                if (sample_ready_in) begin
                    state_next = en_in ? RUN : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_reg        <= IDLE;
            acc_reg          <= '0;
            tune_reg         <= '0;
            sample_out       <= '0;
            sample_valid_out <= 1'b0;
            wrap_out         <= 1'b0;
        end else begin
            state_reg        <= state_next;
            acc_reg          <= acc_next;
            tune_reg         <= tune_next;
            sample_out       <= sample_next;
            sample_valid_out <= valid_next;
            wrap_out         <= wrap_next;
        end
    end

endmodule

// File: tb/tb_lut_phase_gen.sv
// ---------------------------------------------------------------------------
// tb_lut_phase_gen
//
// Self-checking bench for lut_phase_gen with default parameters. The LUT is
// modelled as rom_data = rom_addr ^ lut_xor, so lut_xor = 0 gives LUT[i] = i.
// The bench combines three kinds of checks:
//   - a table of per-cycle vectors,
//   - directed multi-cycle sequences,
//   - a randomized run compared against a phase/sample reference model.
// ---------------------------------------------------------------------------
module tb_lut_phase_gen;

    localparam int PHASE_W = 24;
    localparam int ADDRW   = 8;
    localparam int WIDTH   = 8;

    logic               clk_in = 1'b0;
    logic               rst_in_n;
    logic               en_in;
    logic [PHASE_W-1:0] tune_word_in;
    logic               tune_load_in;
    logic               phase_clr_in;
    logic [ADDRW-1:0]   rom_addr_out;
    logic [WIDTH-1:0]   rom_data_in;
    logic [WIDTH-1:0]   sample_out;
    logic               sample_valid_out;
    logic               sample_ready_in;
    logic               wrap_out;

    logic [7:0]         lut_xor = 8'h00;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    longint m_phase;
    longint m_tune;
    int     m_sample;
    bit     m_valid;
    bit     m_wrap;

    always #5 clk_in = ~clk_in;

    assign rom_data_in = rom_addr_out ^ lut_xor;

    lut_phase_gen #(
        .PHASE_W(PHASE_W),
        .ADDRW  (ADDRW),
        .WIDTH  (WIDTH)
    ) dut (
        .clk_in          (clk_in),
        .rst_in_n        (rst_in_n),
        .en_in           (en_in),
        .tune_word_in    (tune_word_in),
        .tune_load_in    (tune_load_in),
        .phase_clr_in    (phase_clr_in),
        .rom_addr_out    (rom_addr_out),
        .rom_data_in     (rom_data_in),
        .sample_out      (sample_out),
        .sample_valid_out(sample_valid_out),
        .sample_ready_in (sample_ready_in),
        .wrap_out        (wrap_out)
    );

    typedef struct {
        logic        en;
        logic        ready;
        logic        clr;
        logic        load;
        logic [23:0] word;
        logic [7:0]  addr;
        logic [7:0]  sample;
        logic        valid;
        logic        wrap;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_tune   = 0;
        m_sample = 0;
        m_valid  = 0;
        m_wrap   = 0;
    endtask

    // One clock of the reference model. The phase is kept as an integer
    // modulo 2^24. The LUT index is the phase divided by 2^16.
    task automatic model_step(input logic e, input logic r, input logic c,
                              input logic l, input logic [23:0] w);
        longint modulus = longint'(1) << PHASE_W;
        int     lut     = int'((m_phase / 65536) % 256) ^ int'(lut_xor);
        longint sum;
        bit     adv     = e && !c && (!m_valid || r);
        if (c) begin
            m_phase = 0;
            m_wrap  = 0;
        end else if (adv) begin
            sum     = m_phase + m_tune;
            m_wrap  = (sum >= modulus);
            m_phase = sum % modulus;
        end else begin
            m_wrap = 0;
        end
        if (adv) begin
            m_sample = lut;
            m_valid  = 1;
        end else if (m_valid && r) begin
            m_valid = 0;
        end
        if (l) m_tune = longint'(w);
    endtask

    // Drive one cycle of inputs at the falling edge. Step the model. Then
    // leave time 1 after the rising edge, when outputs are sampled.
    task automatic step(input logic e, input logic r, input logic c,
                        input logic l, input logic [23:0] w);
        @(negedge clk_in);
        en_in           = e;
        sample_ready_in = r;
        phase_clr_in    = c;
        tune_load_in    = l;
        tune_word_in    = w;
        model_step(e, r, c, l, w);
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in_n        = 1'b0;
        en_in           = 1'b0;
        sample_ready_in = 1'b0;
        phase_clr_in    = 1'b0;
        tune_load_in    = 1'b0;
        tune_word_in    = '0;
        model_reset();
        repeat (2) @(negedge clk_in);
        rst_in_n = 1'b1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_addr"},   32'(rom_addr_out),     32'((m_phase / 65536) % 256));
        check({tag, "_sample"}, 32'(sample_out),       32'(m_sample));
        check({tag, "_valid"},  32'(sample_valid_out), 32'(m_valid));
        check({tag, "_wrap"},   32'(wrap_out),         32'(m_wrap));
    endtask

    initial begin
        int wraps;

        // Reset state, checked while the reset is still held.
        rst_in_n = 1'b0;
        en_in = 0; sample_ready_in = 0; phase_clr_in = 0; tune_load_in = 0; tune_word_in = '0;
        model_reset();
        #12;
        check("rst_addr",   32'(rom_addr_out), 0);
        check("rst_sample", 32'(sample_out), 0);
        check("rst_valid",  32'(sample_valid_out), 0);
        check("rst_wrap",   32'(wrap_out), 0);
        do_reset();

        // Vector table: the tune change takes effect after the cycle that
        // loads it. Then a clear, then output draining.
        vecs[0] = '{en:0, ready:1, clr:0, load:1, word:24'h010000, addr:0, sample:0, valid:0, wrap:0};
        vecs[1] = '{en:1, ready:1, clr:0, load:1, word:24'h020000, addr:1, sample:0, valid:1, wrap:0};
        vecs[2] = '{en:1, ready:1, clr:0, load:0, word:24'h0,      addr:3, sample:1, valid:1, wrap:0};
        vecs[3] = '{en:1, ready:1, clr:0, load:0, word:24'h0,      addr:5, sample:3, valid:1, wrap:0};
        vecs[4] = '{en:1, ready:1, clr:1, load:0, word:24'h0,      addr:0, sample:3, valid:0, wrap:0};
        vecs[5] = '{en:1, ready:1, clr:0, load:0, word:24'h0,      addr:2, sample:0, valid:1, wrap:0};
        vecs[6] = '{en:0, ready:1, clr:0, load:0, word:24'h0,      addr:2, sample:0, valid:0, wrap:0};
        vecs[7] = '{en:0, ready:0, clr:0, load:0, word:24'h0,      addr:2, sample:0, valid:0, wrap:0};
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].en, vecs[i].ready, vecs[i].clr, vecs[i].load, vecs[i].word);
            check($sformatf("vec%0d_addr", i),   32'(rom_addr_out),     32'(vecs[i].addr));
            check($sformatf("vec%0d_sample", i), 32'(sample_out),       32'(vecs[i].sample));
            check($sformatf("vec%0d_valid", i),  32'(sample_valid_out), 32'(vecs[i].valid));
            check($sformatf("vec%0d_wrap", i),   32'(wrap_out),         32'(vecs[i].wrap));
            $display("vec %0d addr=%0d sample=%0d valid=%0b wrap=%0b", i, rom_addr_out, sample_out, sample_valid_out, wrap_out);
        end

        // Full sweep: a step of one LUT entry per sample. The sequence is
        // 0..255 followed by 0, with a wrap pulse alongside sample 255.
        do_reset();
        step(0, 1, 0, 1, 24'h010000);
        wraps = 0;
        for (int i = 0; i < 257; i++) begin
            step(1, 1, 0, 0, 24'h0);
            check($sformatf("sweep%0d_sample", i), 32'(sample_out), 32'(i % 256));
            check($sformatf("sweep%0d_wrap", i),   32'(wrap_out),   32'(i % 256 == 255));
            if (wrap_out) wraps++;
        end
        check("sweep_wrap_count", 32'(wraps), 1);
        $display("sweep done wraps=%0d", wraps);

        // Fractional step of 1.5 LUT entries.
        do_reset();
        step(0, 1, 0, 1, 24'h018000);
        for (int k = 1; k <= 8; k++) begin
            step(1, 1, 0, 0, 24'h0);
            check($sformatf("frac%0d_addr", k), 32'(rom_addr_out), 32'((k * 3) / 2));
            $display("frac step %0d addr=%0d", k, rom_addr_out);
        end

        // Backpressure: hold sample 3 for five cycles, then resume.
        do_reset();
        step(0, 1, 0, 1, 24'h010000);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 24'h0);
        check("pre_stall_sample", 32'(sample_out), 3);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 24'h0);
            check($sformatf("stall%0d_sample", i), 32'(sample_out), 3);
            check($sformatf("stall%0d_valid", i),  32'(sample_valid_out), 1);
            check($sformatf("stall%0d_addr", i),   32'(rom_addr_out), 4);
            $display("stall %0d sample=%0d valid=%0b addr=%0d", i, sample_out, sample_valid_out, rom_addr_out);
        end
        step(1, 1, 0, 0, 24'h0);
        check("resume_sample", 32'(sample_out), 4);
        check("resume_valid",  32'(sample_valid_out), 1);
        step(1, 1, 0, 0, 24'h0);
        check("resume2_sample", 32'(sample_out), 5);

        // Asynchronous reset in the middle of a stall.
        step(1, 0, 0, 0, 24'h0);
        check("prereset_valid", 32'(sample_valid_out), 1);
        lut_xor = 8'hA5;
        #3;
        rst_in_n = 1'b0;
        #1;
        check("async_rst_sample", 32'(sample_out), 0);
        check("async_rst_valid",  32'(sample_valid_out), 0);
        check("async_rst_wrap",   32'(wrap_out), 0);
        check("async_rst_addr",   32'(rom_addr_out), 0);
        $display("async reset sample=%0d valid=%0b", sample_out, sample_valid_out);
        model_reset();
        @(negedge clk_in);
        rst_in_n = 1'b1;
        step(1, 1, 0, 0, 24'h0);
        check("post_rst_sample", 32'(sample_out), 32'h A5);
        check("post_rst_valid",  32'(sample_valid_out), 1);
        // The tuning word is zero after reset, so the same entry repeats.
        step(1, 1, 0, 0, 24'h0);
        check("tune0_sample", 32'(sample_out), 32'h A5);
        check("tune0_addr",   32'(rom_addr_out), 0);

        // Randomized run against the reference model.
        do_reset();
        lut_xor = 8'($urandom);
        for (int i = 0; i < 3000; i++) begin
            logic        e = ($urandom_range(0, 9) != 0);
            logic        r = ($urandom_range(0, 9) < 7);
            logic        c = ($urandom_range(0, 19) == 0);
            logic        l = ($urandom_range(0, 9) == 0);
            logic [23:0] w = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom_range(0, 24'h0C0000));
            step(e, r, c, l, w);
            check_model($sformatf("rand%0d", i));
            if (i % 500 == 0)
                $display("rand %0d addr=%0d sample=%0h valid=%0b wrap=%0b", i, rom_addr_out, sample_out, sample_valid_out, wrap_out);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
